// File: rtl/rv32_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32_mem_bridge : serialises rv32i fetch/data ports onto one req/ack bus |
// |                   with core stall generation and per-access timeout.     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module rv32_mem_bridge #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_i_addr,
  input  logic        mem_i_rstrb,
  output logic [31:0] mem_i_rdata,
  output logic        mem_i_rbusy,
  input  logic [31:0] mem_d_addr,
  input  logic [31:0] mem_d_wdata,
  input  logic [3:0]  mem_d_wmask,
  input  logic        mem_d_wstrb,
  input  logic        mem_d_rstrb,
  output logic [31:0] mem_d_rdata,
  output logic        mem_d_rbusy,
  output logic        mem_d_wbusy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam int unsigned    C_CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [C_CW-1:0] C_TO_LAST = (TIMEOUT == 0) ? '0 : C_CW'(TIMEOUT - 1);
  localparam bit             C_TO_EN   = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_I  = 3'd1,
    S_REQ_D  = 3'd2,
    S_RESP_I = 3'd3,
    S_RESP_D = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [31:0]       r_bus_addr;
  logic [31:0]       r_bus_wdata;
  logic [3:0]        r_bus_wmask;
  logic              r_bus_err;
  logic [31:0]       r_resp;
  logic [C_CW-1:0]   r_cnt;

  logic w_start_d;
  logic w_start_i;
  logic w_ack_take;
  logic w_abort;
  logic w_to_hit;
  logic w_unused;

  // Bus is word addressed; the byte offset is carried by the write mask.
  assign w_unused = ^{mem_i_addr[1:0], mem_d_addr[1:0]};
  assign w_to_hit = C_TO_EN && (r_cnt == C_TO_LAST);

  always_comb begin
    w_state_next = r_state;
    w_start_d    = 1'b0;
    w_start_i    = 1'b0;
    w_ack_take   = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_d_wstrb || mem_d_rstrb) begin
          w_start_d    = 1'b1;
          w_state_next = S_REQ_D;
        end else if (mem_i_rstrb) begin
          w_start_i    = 1'b1;
          w_state_next = S_REQ_I;
        end
      end
      S_REQ_I, S_REQ_D: begin
        // A real ack always wins over an expiring timeout in the same cycle.
        if (bus_ack) begin
          w_ack_take   = 1'b1;
          w_state_next = (r_state == S_REQ_I) ? S_RESP_I : S_RESP_D;
        end else if (w_to_hit) begin
          w_abort      = 1'b1;
          w_state_next = (r_state == S_REQ_I) ? S_RESP_I : S_RESP_D;
        end
      end
      S_RESP_I, S_RESP_D: w_state_next = S_IDLE;
      default:            w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wmask <= '0;
      r_bus_err   <= 1'b0;
      r_resp      <= '0;
      r_cnt       <= '0;
    end else begin
      r_bus_err <= w_abort;
      if (w_start_d) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= mem_d_wstrb;
        r_bus_addr  <= {mem_d_addr[31:2], 2'b00};
        r_bus_wdata <= mem_d_wdata;
        r_bus_wmask <= mem_d_wstrb ? mem_d_wmask : 4'b0000;
        r_cnt       <= '0;
      end else if (w_start_i) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= 1'b0;
        r_bus_addr  <= {mem_i_addr[31:2], 2'b00};
        r_bus_wmask <= 4'b0000;
        r_cnt       <= '0;
      end else if (w_ack_take) begin
        r_bus_req <= 1'b0;
        r_resp    <= bus_rdata;
      end else if (w_abort) begin
        r_bus_req <= 1'b0;
        r_resp    <= ERR_RDATA;
      end else if (r_bus_req) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus_req     = r_bus_req;
  assign bus_we      = r_bus_we;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign bus_wmask   = r_bus_wmask;
  assign bus_err     = r_bus_err;
  assign mem_i_rdata = r_resp;
  assign mem_d_rdata = r_resp;

  // Stall is released only in the cycle that presents that port's response.
  assign mem_i_rbusy = mem_i_rstrb && (r_state != S_RESP_I);
  assign mem_d_rbusy = mem_d_rstrb && (r_state != S_RESP_D);
  assign mem_d_wbusy = mem_d_wstrb && (r_state != S_RESP_D);

endmodule
`default_nettype wire

// File: tb/tb_rv32_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rv32_mem_bridge : directed + randomized bench with transaction model  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_rv32_mem_bridge;

  localparam int unsigned C_TIMEOUT = 4;
  localparam logic [31:0] C_ERR     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_i_addr;
  logic        mem_i_rstrb;
  logic [31:0] mem_i_rdata;
  logic        mem_i_rbusy;
  logic [31:0] mem_d_addr;
  logic [31:0] mem_d_wdata;
  logic [3:0]  mem_d_wmask;
  logic        mem_d_wstrb;
  logic        mem_d_rstrb;
  logic [31:0] mem_d_rdata;
  logic        mem_d_rbusy;
  logic        mem_d_wbusy;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  rv32_mem_bridge #(.TIMEOUT(C_TIMEOUT), .ERR_RDATA(C_ERR)) dut (
    .clk(clk), .rst(rst),
    .mem_i_addr(mem_i_addr), .mem_i_rstrb(mem_i_rstrb),
    .mem_i_rdata(mem_i_rdata), .mem_i_rbusy(mem_i_rbusy),
    .mem_d_addr(mem_d_addr), .mem_d_wdata(mem_d_wdata), .mem_d_wmask(mem_d_wmask),
    .mem_d_wstrb(mem_d_wstrb), .mem_d_rstrb(mem_d_rstrb),
    .mem_d_rdata(mem_d_rdata), .mem_d_rbusy(mem_d_rbusy), .mem_d_wbusy(mem_d_wbusy),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wmask(bus_wmask), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: at most one bus access in flight; a
  // finished access yields exactly one response cycle for its port.
  bit          m_valid = 1'b0;
  bit          m_active;
  bit          m_port_d;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  int          m_waited;
  int          m_resp_port;   // 0 none, 1 fetch, 2 data
  logic [31:0] m_resp;
  bit          m_err;
  int          m_next_port;

  always @(posedge clk) begin
    if (rst) begin
      m_valid     = 1'b1;
      m_active    = 1'b0;
      m_resp_port = 0;
      m_resp      = '0;
      m_err       = 1'b0;
      m_waited    = 0;
    end else if (m_valid) begin
      m_err       = 1'b0;
      m_next_port = 0;
      if (m_active) begin
        if (bus_ack) begin
          m_resp      = bus_rdata;
          m_next_port = m_port_d ? 2 : 1;
          m_active    = 1'b0;
        end else if (C_TIMEOUT != 0 && m_waited == int'(C_TIMEOUT) - 1) begin
          m_resp      = C_ERR;
          m_err       = 1'b1;
          m_next_port = m_port_d ? 2 : 1;
          m_active    = 1'b0;
        end else begin
          m_waited++;
        end
      end else if (m_resp_port == 0) begin
        if (mem_d_wstrb || mem_d_rstrb) begin
          m_active = 1'b1; m_port_d = 1'b1; m_we = mem_d_wstrb;
          m_addr   = mem_d_addr; m_wdata = mem_d_wdata;
          m_wmask  = mem_d_wstrb ? mem_d_wmask : 4'b0000;
          m_waited = 0;
        end else if (mem_i_rstrb) begin
          m_active = 1'b1; m_port_d = 1'b0; m_we = 1'b0;
          m_addr   = mem_i_addr; m_wmask = 4'b0000;
          m_waited = 0;
        end
      end
      m_resp_port = m_next_port;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("bus_req", bus_req, m_active);
      check("bus_err", bus_err, m_err);
      if (m_active) begin
        check("bus_addr", bus_addr, {m_addr[31:2], 2'b00});
        check("bus_we", bus_we, m_we);
        check("bus_wmask", bus_wmask, m_wmask);
        if (m_we) check("bus_wdata", bus_wdata, m_wdata);
      end
      check("mem_i_rdata", mem_i_rdata, m_resp);
      check("mem_d_rdata", mem_d_rdata, m_resp);
      check("mem_i_rbusy", mem_i_rbusy, mem_i_rstrb && m_resp_port != 1);
      check("mem_d_rbusy", mem_d_rbusy, mem_d_rstrb && m_resp_port != 2);
      check("mem_d_wbusy", mem_d_wbusy, mem_d_wstrb && m_resp_port != 2);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet();
    mem_i_rstrb = 1'b0; mem_d_rstrb = 1'b0; mem_d_wstrb = 1'b0; bus_ack = 1'b0;
  endtask

  initial begin
    int errs;
    rst = 1'b1;
    mem_i_addr = '0; mem_d_addr = '0; mem_d_wdata = '0; mem_d_wmask = '0;
    bus_rdata = '0;
    quiet();
    tick(); tick();
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_bus_wmask", bus_wmask, 0);
    check("rst_rdata", mem_i_rdata, 0);
    rst = 1'b0;
    tick();

    // Fetch, zero wait states
    mem_i_rstrb = 1'b1; mem_i_addr = 32'h100; settle();
    check("t1_c0_rbusy", mem_i_rbusy, 1);
    tick(); bus_ack = 1'b1; bus_rdata = 32'h0050_0093; settle();
    check("t1_c1_req", bus_req, 1);
    check("t1_c1_addr", bus_addr, 32'h100);
    check("t1_c1_we", bus_we, 0);
    check("t1_c1_rbusy", mem_i_rbusy, 1);
    tick(); bus_ack = 1'b0; settle();
    check("t1_c2_rbusy", mem_i_rbusy, 0);
    check("t1_c2_rdata", mem_i_rdata, 32'h0050_0093);
    tick(); quiet(); tick();

    // Byte store with three wait states
    mem_d_wstrb = 1'b1; mem_d_addr = 32'h203; mem_d_wmask = 4'b1000;
    mem_d_wdata = 32'hAAAA_AAAA; settle();
    check("t2_c0_wbusy", mem_d_wbusy, 1);
    for (int k = 1; k <= 4; k++) begin
      tick(); bus_ack = (k == 4); bus_rdata = 32'h5555_0000; settle();
      check("t2_req", bus_req, 1);
      check("t2_addr", bus_addr, 32'h200);
      check("t2_we", bus_we, 1);
      check("t2_wmask", bus_wmask, 4'b1000);
      check("t2_wbusy", mem_d_wbusy, 1);
    end
    tick(); bus_ack = 1'b0; settle();
    check("t2_c5_wbusy", mem_d_wbusy, 0);
    tick(); quiet(); tick();

    // Fetch and load together: load first
    mem_i_rstrb = 1'b1; mem_i_addr = 32'h400; mem_d_rstrb = 1'b1; mem_d_addr = 32'h800;
    tick(); bus_ack = 1'b1; bus_rdata = 32'h1111_1111; settle();
    check("t3_c1_addr", bus_addr, 32'h800);
    check("t3_c1_ibusy", mem_i_rbusy, 1);
    tick(); bus_ack = 1'b0; settle();
    check("t3_c2_dbusy", mem_d_rbusy, 0);
    check("t3_c2_drdata", mem_d_rdata, 32'h1111_1111);
    check("t3_c2_ibusy", mem_i_rbusy, 1);
    tick(); mem_d_rstrb = 1'b0; settle();
    check("t3_c3_ibusy", mem_i_rbusy, 1);
    tick(); bus_ack = 1'b1; bus_rdata = 32'h2222_2222; settle();
    check("t3_c4_addr", bus_addr, 32'h400);
    check("t3_c4_ibusy", mem_i_rbusy, 1);
    tick(); bus_ack = 1'b0; settle();
    check("t3_c5_ibusy", mem_i_rbusy, 0);
    check("t3_c5_irdata", mem_i_rdata, 32'h2222_2222);
    tick(); quiet(); tick();

    // Fetch timeout with no ack
    mem_i_rstrb = 1'b1; mem_i_addr = 32'h500; errs = 0;
    for (int k = 1; k <= 4; k++) begin
      tick(); settle();
      check("t4_req", bus_req, 1);
      check("t4_busy", mem_i_rbusy, 1);
      errs += int'(bus_err);
    end
    check("t4_err_early", errs, 0);
    tick(); settle();
    check("t4_c5_rbusy", mem_i_rbusy, 0);
    check("t4_c5_rdata", mem_i_rdata, 32'h0000_0013);
    check("t4_c5_err", bus_err, 1);
    check("t4_c5_req", bus_req, 0);
    tick(); quiet(); settle();
    check("t4_c6_err", bus_err, 0);
    tick();

    // Reset while a load is on the bus
    mem_d_rstrb = 1'b1; mem_d_addr = 32'h600;
    tick(); settle();
    check("t5_c1_req", bus_req, 1);
    rst = 1'b1;
    tick(); rst = 1'b0; mem_d_rstrb = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h3333_3333; settle();
    check("t5_c2_req", bus_req, 0);
    check("t5_c2_rdata", mem_d_rdata, 0);
    tick(); bus_ack = 1'b0; settle();
    check("t5_c3_req", bus_req, 0);
    check("t5_c3_rdata", mem_d_rdata, 0);
    tick();

    // Word load; data persists after strobe drops
    mem_d_rstrb = 1'b1; mem_d_addr = 32'h1000;
    tick(); settle();
    check("t6_c1_wmask", bus_wmask, 0);
    check("t6_c1_addr", bus_addr, 32'h1000);
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick(); bus_ack = 1'b0; settle();
    check("t6_c2_rbusy", mem_d_rbusy, 0);
    check("t6_c2_rdata", mem_d_rdata, 32'hDEAD_BEEF);
    tick(); mem_d_rstrb = 1'b0;
    tick(); tick(); settle();
    check("t6_hold_rdata", mem_d_rdata, 32'hDEAD_BEEF);

    // Randomized traffic with random slave latency and occasional reset
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst         = ($urandom_range(0, 199) == 0);
      mem_i_rstrb = $urandom_range(0, 1) == 1;
      mem_d_rstrb = $urandom_range(0, 2) == 0;
      mem_d_wstrb = $urandom_range(0, 2) == 0;
      mem_i_addr  = $urandom;
      mem_d_addr  = $urandom;
      mem_d_wdata = $urandom;
      mem_d_wmask = 4'($urandom_range(0, 15));
      bus_ack     = $urandom_range(0, 2) == 0;
      bus_rdata   = $urandom;
    end
    tick(); rst = 1'b0; quiet();
    repeat (8) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
